// File: rtl/div_iter_unit_pkg.sv
// Shared state codes and handshake constants for the iterative divider.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0;

endpackage

// File: rtl/div_sign_fix.sv
// Two-lane conditional two's-complement negate: abs on the way in,
// sign restore on the way out.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_a,
    input  logic [WIDTH-1:0] val_b,
    input  logic             neg_a,
    input  logic             neg_b,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_b
);

    assign res_a = neg_a ? -val_a : val_a;
    assign res_b = neg_b ? -val_b : val_b;

endmodule

// File: rtl/div_iter_unit.sv
// Iterative restoring DIV/DIVU for EX; result is {remainder, quotient}.
// Optional DIV_EARLY_EXIT_EN skips iteration when |a| < |b|.
import div_iter_unit_pkg::*;

module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, b_abs;
    logic             sgn, a_neg, b_neg, bypass;
    logic [WIDTH-1:0] a_abs_in, b_abs_in, quo_fix, rem_fix;
    logic [WIDTH:0]   trial;
    logic             in_a_neg, in_b_neg;
    logic             div_zero, early, go;

    assign in_a_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign in_b_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign div_zero = (opdata2_i == '0);
    assign go       = (start_i == DivStart) & ~annul_i;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs (
        .val_a (opdata1_i),
        .val_b (opdata2_i),
        .neg_a (in_a_neg),
        .neg_b (in_b_neg),
        .res_a (a_abs_in),
        .res_b (b_abs_in)
    );

    // bypass results (div-by-zero, early exit) are already final
    div_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .val_a (quo),
        .val_b (rem),
        .neg_a (~bypass & sgn & (a_neg ^ b_neg)),
        .neg_b (~bypass & sgn & a_neg),
        .res_a (quo_fix),
        .res_b (rem_fix)
    );

`ifdef DIV_EARLY_EXIT_EN
    assign early = (a_abs_in < b_abs_in);
`else
    assign early = 1'b0;
`endif

    assign trial = {rem, quo[WIDTH-1]} - {1'b0, b_abs};

    always_ff @(posedge clk) begin
        if (rst) state <= DivFree;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DivFree: begin
                if (go)
                    state_nxt = (div_zero | early) ? DivByZero : DivOn;
            end
            DivByZero: begin
                state_nxt = annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                if (annul_i)
                    state_nxt = DivFree;
                else if (cnt == CNT_W'(WIDTH - 1))
                    state_nxt = DivEnd;
            end
            DivEnd: begin
                if (start_i == DivStop)
                    state_nxt = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            b_abs    <= '0;
            sgn      <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            bypass   <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            unique case (state)
                DivFree: begin
                    result_o <= '0;
                    ready_o  <= DivResultNotReady;
                    if (go) begin
                        sgn   <= signed_div_i;
                        a_neg <= in_a_neg;
                        b_neg <= in_b_neg;
                        b_abs <= b_abs_in;
                        cnt   <= '0;
                        if (div_zero) begin
                            bypass <= 1'b1;
                            rem    <= opdata1_i;
                            quo    <= '1;
                        end else if (early) begin
                            bypass <= 1'b1;
                            rem    <= opdata1_i;
                            quo    <= '0;
                        end else begin
                            bypass <= 1'b0;
                            rem    <= '0;
                            quo    <= a_abs_in;
                        end
                    end
                end
                DivByZero: begin
                end
                DivOn: begin
                    if (!annul_i) begin
                        cnt <= cnt + CNT_W'(1);
                        if (!trial[WIDTH]) begin
                            rem <= trial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DivResultReady;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed-vector bench for div_iter_unit; expected values hand-computed.
// Early-exit latency expectations follow DIV_EARLY_EXIT_EN.
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_iter_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

`ifdef DIV_EARLY_EXIT_EN
    localparam int EarlyLat = 2;
`else
    localparam int EarlyLat = 33;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string tag, input logic sd,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [63:0] exp_res,
                           input int hold);
        int cyc;
        logic [63:0] first;
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        opdata1_i = ~a;
        opdata2_i = 32'h5;
        cyc = 0;
        while (!ready_o && cyc < 60) begin
            tick();
            cyc++;
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_res"}, result_o, exp_res);
        first = result_o;
        for (int i = 0; i < hold; i++) begin
            opdata1_i = 32'(i * 77);
            tick();
            check_eq({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
            check_eq({tag, "_hold_res"}, result_o, first);
        end
        start_i = 1'b0;
        tick();
        check_eq({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        check_eq({tag, "_drop_res"}, result_o, 64'd0);
    endtask

    task automatic abort_run(input string tag, input logic use_rst);
        logic seen;
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();
        repeat (9) tick();
        start_i = 1'b0;
        if (use_rst) rst = 1'b1;
        else         annul_i = 1'b1;
        tick();
        rst     = 1'b0;
        annul_i = 1'b0;
        check_eq({tag, "_rdy0"}, 64'(ready_o), 64'd0);
        check_eq({tag, "_res0"}, result_o, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= ready_o;
        end
        check_eq({tag, "_never_rdy"}, 64'(seen), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        tick();
        tick();
        check_eq("rst_rdy", 64'(ready_o), 64'd0);
        check_eq("rst_res", result_o, 64'd0);
        rst = 1'b0;
        tick();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33,
                {32'd2, 32'd14}, 0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
                {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33,
                {32'd1, 32'hFFFF_FFFD}, 0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
                {32'd0, 32'h8000_0000}, 0);
        run_div("divu_by0", 1'b0, 32'h1234, 32'd0, 2,
                {32'h0000_1234, 32'hFFFF_FFFF}, 0);
        run_div("div_m5_by0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2,
                {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0);
        run_div("divu_3_10", 1'b0, 32'd3, 32'd10, EarlyLat,
                {32'd3, 32'd0}, 0);
        run_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, EarlyLat,
                {32'hFFFF_FFFD, 32'd0}, 0);

        abort_run("annul", 1'b0);
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 33,
                {32'd0, 32'd3}, 0);
        abort_run("reset", 1'b1);
        run_div("after_rst", 1'b0, 32'd9, 32'd3, 33,
                {32'd0, 32'd3}, 0);

        run_div("hold", 1'b0, 32'd100, 32'd7, 33,
                {32'd2, 32'd14}, 5);
        run_div("divu_max_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 33,
                {32'd0, 32'h5555_5555}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
